vpu_scanout_fifo: RTL and testbench

- Elastic pixel buffer directly downstream of the VPU core's BG/colour-merge output.
- The core emits one merged pixel every 4 clk during the visible part of a line and nothing during blanking. It cannot stall.
- This block captures those pixels, strips alpha, tags start-of-frame and end-of-line, and presents a valid/ready stream to the display/encoder side.
- It detects overflow and frame-structure errors and resynchronises on the next frame start.

---
 rtl/gameconsole_pkg.sv | 21 ++
 rtl/vpu_scanout_ram.sv | 25 ++
 rtl/vpu_scanout_fifo.sv | 146 ++++++++++++++
 tb/tb_vpu_scanout_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gameconsole_pkg.sv
// Shared types and defaults for the VPU scanout path: stored word layout,
// scanout FSM states and default screen geometry.
package gameconsole_pkg;

   localparam int SCREEN_W_DFLT = 320;
   localparam int SCREEN_H_DFLT = 240;
   localparam int SCANOUT_DEPTH = 512;

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [23:0] rgb;
   } scan_word_t;

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      RUN       = 2'd1,
      RESYNC    = 2'd2
   } scan_state_t;

endpackage

// File: rtl/vpu_scanout_ram.sv
// Simple dual-port DEPTH x WIDTH storage with registered read data,
// written so synthesis maps it onto block RAM.
module vpu_scanout_ram
   import gameconsole_pkg::*;
#(
   parameter int DEPTH = SCANOUT_DEPTH,
   parameter int WIDTH = $bits(scan_word_t)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/vpu_scanout_fifo.sv
// Elastic scanout buffer between the VPU colour-merge stage and the display side.
// Optional build macro VPU_SCANOUT_BGFILL_EN replaces fully transparent pixels with bg_color.
//
// state     | meaning
// SYNC_WAIT | after reset: drop input until a start-of-frame pixel
// RUN       | every incoming pixel is written
// RESYNC    | after overflow: FIFO flushed, drop input until start-of-frame
module vpu_scanout_fifo
   import gameconsole_pkg::*;
#(
   parameter int DEPTH    = SCANOUT_DEPTH,
   parameter int SCREEN_W = SCREEN_W_DFLT,
   parameter int SCREEN_H = SCREEN_H_DFLT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [31:0]              in_color,
   input  logic                     in_sof,
   input  logic [23:0]              bg_color,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [23:0]              out_rgb,
   output logic                     out_sof,
   output logic                     out_eol,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     frame_err,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = AW + 1;
   localparam int XW = $clog2(SCREEN_W);
   localparam int YW = $clog2(SCREEN_H);
   localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

   scan_state_t   state;
   scan_word_t    out_word, wword;
   logic [PW-1:0] wptr, rptr;
   logic [XW-1:0] wx;
   logic [YW-1:0] wy;
   logic          pf;
   logic [25:0]   ram_q;
   logic [23:0]   rgb_sel;
   logic          rd_fire, full, accept, ovf_evt, ferr_evt;
   logic          ram_empty, out_free, bypass, ram_we, ram_re;

`ifndef VPU_SCANOUT_BGFILL_EN
   logic unused_bg;
   assign unused_bg = ^{bg_color, in_color[31:24]};
`endif

   always_comb begin
      rd_fire = out_valid & out_ready;
      full    = (level == LW'(DEPTH));
      if (state == RUN) accept = in_valid & (~full | rd_fire);
      else              accept = in_valid & in_sof;
      ovf_evt  = (state == RUN) & in_valid & full & ~rd_fire;
      ferr_evt = (state == RUN) & accept & in_sof & ((wx != '0) | (wy != '0));
      rgb_sel  = in_color[23:0];
`ifdef VPU_SCANOUT_BGFILL_EN
      if (in_color[31:24] == 8'h00) rgb_sel = bg_color;
`endif
      wword.sof = in_sof;
      wword.eol = ~in_sof & (wx == X_LAST);
      wword.rgb = rgb_sel;
      ram_empty = (wptr == rptr);
      out_free  = ~out_valid | rd_fire;
      // With the RAM and read pipe empty, a new word goes straight to the output stage
      bypass    = accept & ram_empty & ~pf & out_free;
      ram_we    = accept & ~bypass;
      ram_re    = ~ram_empty & ~pf & out_free;
   end

   vpu_scanout_ram #(.DEPTH(DEPTH), .WIDTH($bits(scan_word_t))) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr[AW-1:0]),
      .wdata (wword),
      .re    (ram_re),
      .raddr (rptr[AW-1:0]),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SYNC_WAIT;
         wptr      <= '0;
         rptr      <= '0;
         pf        <= 1'b0;
         out_valid <= 1'b0;
         out_word  <= '0;
         level     <= '0;
         wx        <= '0;
         wy        <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= ovf_evt  | (overflow  & ~err_clr);
         frame_err <= ferr_evt | (frame_err & ~err_clr);
         if (ovf_evt) begin
            state     <= RESYNC;
            wptr      <= '0;
            rptr      <= '0;
            pf        <= 1'b0;
            out_valid <= 1'b0;
            level     <= '0;
         end else begin
            if (ram_we) wptr <= wptr + PW'(1);
            if (ram_re) rptr <= rptr + PW'(1);
            pf <= ram_re;
            // A pending RAM read only exists while the output stage is empty
            if (pf) begin
               out_valid <= 1'b1;
               out_word  <= scan_word_t'(ram_q);
            end else if (bypass) begin
               out_valid <= 1'b1;
               out_word  <= wword;
            end else if (rd_fire) begin
               out_valid <= 1'b0;
            end
            level <= level + LW'(accept) - LW'(rd_fire);
            if (accept) begin
               state <= RUN;
               if (in_sof) begin
                  wx <= XW'(1);
                  wy <= '0;
               end else if (wx == X_LAST) begin
                  wx <= '0;
                  wy <= (wy == Y_LAST) ? '0 : wy + YW'(1);
               end else begin
                  wx <= wx + XW'(1);
               end
            end
         end
      end
   end

   assign out_rgb = out_word.rgb;
   assign out_sof = out_word.sof;
   assign out_eol = out_word.eol;

endmodule

// File: tb/tb_vpu_scanout_fifo.sv
// Directed plus randomized bench for vpu_scanout_fifo on a reduced screen geometry,
// checked against a queue-based model of the pixel stream.
module tb_vpu_scanout_fifo;

   localparam int DEPTH = 64;
   localparam int W     = 20;
   localparam int H     = 6;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_sof, out_valid, out_ready;
   logic          out_sof, out_eol, overflow, frame_err, err_clr;
   logic [31:0]   in_color;
   logic [23:0]   bg_color, out_rgb;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   vpu_scanout_fifo #(.DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_color  (in_color),
      .in_sof    (in_sof),
      .bg_color  (bg_color),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rgb   (out_rgb),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .level     (level),
      .overflow  (overflow),
      .frame_err (frame_err),
      .err_clr   (err_clr)
   );

   int          total = 0;
   int          bad   = 0;
   logic [25:0] expq[$];
   bit          locked, m_ovf, m_ferr;
   int          pidx;
   int          n_words, n_eol, n_sof, last_eol_word;
   logic [23:0] last_rgb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input logic [31:0] c, input logic [23:0] bg);
`ifdef VPU_SCANOUT_BGFILL_EN
      if (c[31:24] == 8'h00) return bg;
`endif
      return c[23:0];
   endfunction

   function automatic logic [31:0] rnd_color();
      logic [31:0] c;
      c = $urandom;
      if ($urandom_range(0, 3) == 0) c[31:24] = 8'h00;
      return c;
   endfunction

   // One clock: drive inputs, advance the model, then check after the edge.
   task automatic cyc(input bit v, input bit s, input logic [31:0] c, input bit rdy, input bit clr);
      bit          hs, flush, fset, pv;
      logic [25:0] pw, e;
      in_valid = v; in_sof = s; in_color = c; out_ready = rdy; err_clr = clr;
      #1;
      pv = out_valid;
      pw = {out_sof, out_eol, out_rgb};
      hs = pv && rdy;
      flush = 0; fset = 0;
      if (hs) begin
         n_words++;
         if (out_eol) begin n_eol++; last_eol_word = n_words; end
         if (out_sof) n_sof++;
         last_rgb = out_rgb;
         if (expq.size() == 0) chk("word_unexpected", 32'(expq.size()), 32'd1);
         else begin
            e = expq.pop_front();
            chk("word", 32'(pw), 32'(e));
         end
      end
      if (v) begin
         if (locked && !(expq.size() < DEPTH || hs)) begin
            flush = 1;
            expq.delete();
            locked = 0;
         end else if (locked || s) begin
            if (s) begin
               if (locked && pidx != 0) fset = 1;
               pidx = 0;
            end
            expq.push_back({s, (pidx % W) == W - 1, exp_rgb(c, bg_color)});
            pidx = (pidx + 1) % (W * H);
            locked = 1;
         end
      end
      m_ovf  = flush | (m_ovf & !clr);
      m_ferr = fset | (m_ferr & !clr);
      @(posedge clk); #1;
      chk("level", 32'(level), 32'(expq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      if (pv && !rdy && !flush) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_word", 32'({out_sof, out_eol, out_rgb}), 32'(pw));
      end
   endtask

   task automatic pixel(input logic [31:0] c, input bit s, input bit rdy);
      cyc(1, s, c, rdy, 0);
      repeat (3) cyc(0, 0, 32'h0, rdy, 0);
   endtask

   task automatic do_reset();
      rst_n = 0; in_valid = 0; in_sof = 0; in_color = 0; out_ready = 0; err_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_word", 32'({out_sof, out_eol, out_rgb}), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      rst_n = 1;
      expq.delete();
      locked = 0; pidx = 0; m_ovf = 0; m_ferr = 0;
   endtask

   initial begin
      int k;
      bg_color = 24'h00FF00;
      do_reset();

      // Pixels before the first start-of-frame are dropped; sof pixel falls through in 1 clk
      repeat (3) pixel(32'hFFAABBCC, 0, 0);
      cyc(1, 1, 32'hFF102030, 0, 0);
      chk("sof_valid", 32'(out_valid), 32'd1);
      chk("sof_rgb", 32'(out_rgb), 32'h102030);
      chk("sof_flag", 32'(out_sof), 32'd1);
      repeat (3) cyc(0, 0, 32'h0, 0, 0);

      // Rest of that frame with the consumer always ready
      n_words = 0; n_eol = 0; n_sof = 0;
      for (int i = 1; i < W * H; i++) pixel(rnd_color(), 0, 1);
      repeat (6) cyc(0, 0, 32'h0, 1, 0);
      chk("frame_words", 32'(n_words), 32'(W * H));
      chk("frame_eols", 32'(n_eol), 32'(H));
      chk("frame_sofs", 32'(n_sof), 32'd1);

      // DEPTH+1 pixels with no consumer: overflow, flush, drop until next sof
      for (int i = 0; i <= DEPTH; i++) pixel(rnd_color(), i == 0, 0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd0);
      chk("ovf_out_valid", 32'(out_valid), 32'd0);
      repeat (3) pixel(rnd_color(), 0, 1);
      chk("resync_drop", 32'(level), 32'd0);
      pixel(32'hFF0000AA, 1, 1);
      repeat (4) pixel(rnd_color(), 0, 1);
      cyc(0, 0, 32'h0, 1, 1);
      chk("ovf_clear", 32'(overflow), 32'd0);

      // Start-of-frame mid-line: frame error, counters restart at that pixel
      while (pidx != 5) pixel(rnd_color(), 0, 1);
      n_words = 0; last_eol_word = 0;
      pixel(rnd_color(), 1, 1);
      chk("ferr_flag", 32'(frame_err), 32'd1);
      for (int i = 1; i <= W; i++) pixel(rnd_color(), 0, 1);
      repeat (4) cyc(0, 0, 32'h0, 1, 0);
      chk("ferr_eol_pos", 32'(last_eol_word), 32'(W));
      cyc(0, 0, 32'h0, 1, 1);
      chk("ferr_clear", 32'(frame_err), 32'd0);

      // Completely full, then write and read in the same cycle
      while (expq.size() < DEPTH) pixel(rnd_color(), 0, 0);
      chk("full_level", 32'(level), 32'(DEPTH));
      cyc(1, 0, rnd_color(), 1, 0);
      chk("full_rw_ovf", 32'(overflow), 32'd0);
      chk("full_rw_level", 32'(level), 32'(DEPTH));
      repeat (DEPTH * 3 + 10) cyc(0, 0, 32'h0, 1, 0);

      // Transparent pixel
      bg_color = 24'h00FF00;
      pixel(32'h00123456, 0, 1);
      repeat (3) cyc(0, 0, 32'h0, 1, 0);
`ifdef VPU_SCANOUT_BGFILL_EN
      chk("bgfill", 32'(last_rgb), 32'h00FF00);
`else
      chk("bgfill", 32'(last_rgb), 32'h123456);
`endif

      // Randomized traffic with a mid-run reset
      for (int i = 0; i < 1600; i++) begin
         bit v, s, r;
         if (i == 800) do_reset();
         v = ($urandom_range(0, 2) == 0);
         s = v && ($urandom_range(0, 15) == 0);
         r = (i < 800) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 63) == 0) bg_color = 24'($urandom);
         cyc(v, s, rnd_color(), r, $urandom_range(0, 31) == 0);
      end

      k = 0;
      while ((expq.size() != 0 || out_valid) && k < 1000) begin
         cyc(0, 0, 32'h0, 1, 0);
         k++;
      end
      chk("drain_empty", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
